// File: rtl/dense_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_seq
// Purpose  : Sequential fixed-point fully-connected layer,
//            y[o] = sat(act((sum_i W[o][i]*x[i] + (b[o] << FRAC)) >>> FRAC)).
//            LANES neurons are evaluated in parallel, one input per cycle,
//            so a run takes G*(N_IN+1)+1 cycles with G = N_OUT/LANES.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (aborts a run, no done)
//   start    in   request evaluation; honoured only while idle
//   relu_en  in   clamp negative results to zero before saturation
//   x        in   N_IN*DW inputs, x[i] at [i*DW +: DW], latched on start
//   W        in   N_OUT*N_IN*WW weights, W[o][i] at [(o*N_IN+i)*WW +: WW],
//                 read live, must stay stable during a run
//   b        in   N_OUT*DW biases, b[o] at [o*DW +: DW], latched on start
//   y        out  N_OUT*DW results, updated atomically with done
//   busy     out  high from the edge after accept through the DONE cycle
//   done     out  one-cycle pulse, y valid
//   sat      out  some output clipped in the last run; held until next start
// ============================================================================
module dense_layer_seq #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int FRAC  = 0,
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [N_IN*DW-1:0]       x,
    input  logic [N_OUT*N_IN*WW-1:0] W,
    input  logic [N_OUT*DW-1:0]      b,
    output logic [N_OUT*DW-1:0]      y,
    output logic                     busy,
    output logic                     done,
    output logic                     sat
);

    localparam int G     = N_OUT / LANES;
    localparam int ACC_W = DW + WW + $clog2(N_IN) + 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] c_ymax  = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_ymin  = ~c_ymax;
    localparam logic [GW-1:0]           c_glast = GW'(G - 1);
    localparam logic [KW-1:0]           c_klast = KW'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   r_state;
    logic [N_IN*DW-1:0]       r_x;
    logic [N_OUT*DW-1:0]      r_b;
    logic [N_OUT*DW-1:0]      r_buf;
    logic                     r_relu;
    logic [GW-1:0]            r_g;
    logic [KW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc [LANES];

    logic signed [DW-1:0]     w_xk;
    logic signed [WW-1:0]     w_wsel [LANES];
    logic signed [DW+WW-1:0]  w_prod [LANES];
    logic signed [DW-1:0]     w_bsel [LANES];
    logic signed [ACC_W-1:0]  w_bias [LANES];
    logic signed [ACC_W-1:0]  w_r    [LANES];
    logic signed [DW-1:0]     w_yval [LANES];
    logic [LANES-1:0]         w_clip;
    logic [GW-1:0]            w_gnext;
    logic [N_OUT*DW-1:0]      w_bsrc;

    // Datapath: MAC products, bias preload for the group about to start,
    // and the shift/ReLU/saturate stage used on WR.
    always_comb begin
        w_xk = r_x[int'(r_k)*DW +: DW];
        // Bias comes straight from the port on accept (not latched yet) and
        // from the latched copy when reloading between groups. The group
        // index is clamped so the select never leaves the vector.
        w_gnext = (r_state == S_IDLE || r_g == c_glast) ? '0 : r_g + GW'(1);
        w_bsrc  = (r_state == S_IDLE) ? b : r_b;
        w_clip  = '0;
        for (int l = 0; l < LANES; l++) begin
            w_wsel[l] = W[((int'(r_g)*LANES + l)*N_IN + int'(r_k))*WW +: WW];
            w_prod[l] = (DW+WW)'(w_xk) * (DW+WW)'(w_wsel[l]);
            w_bsel[l] = w_bsrc[(int'(w_gnext)*LANES + l)*DW +: DW];
            w_bias[l] = ACC_W'(w_bsel[l]) <<< FRAC;
            w_r[l]    = r_acc[l] >>> FRAC;
            if (r_relu && w_r[l][ACC_W-1]) begin
                w_r[l] = '0;
            end
            if (w_r[l] > c_ymax) begin
                w_yval[l] = c_ymax[DW-1:0];
                w_clip[l] = 1'b1;
            end else if (w_r[l] < c_ymin) begin
                w_yval[l] = c_ymin[DW-1:0];
                w_clip[l] = 1'b1;
            end else begin
                w_yval[l] = w_r[l][DW-1:0];
            end
        end
    end

    // Control FSM and all state. busy is registered from the state, so it
    // rises one edge after accept and falls on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_b     <= '0;
            r_buf   <= '0;
            r_relu  <= 1'b0;
            r_g     <= '0;
            r_k     <= '0;
            y       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_acc[l] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_x     <= x;
                        r_b     <= b;
                        r_relu  <= relu_en;
                        r_g     <= '0;
                        r_k     <= '0;
                        sat     <= 1'b0;
                        for (int l = 0; l < LANES; l++) begin
                            r_acc[l] <= w_bias[l];
                        end
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    busy <= 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        r_acc[l] <= r_acc[l] + ACC_W'(w_prod[l]);
                    end
                    if (r_k == c_klast) begin
                        r_k     <= '0;
                        r_state <= S_WR;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_WR: begin
                    busy <= 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        r_buf[(int'(r_g)*LANES + l)*DW +: DW] <= w_yval[l];
                    end
                    if (|w_clip) begin
                        sat <= 1'b1;
                    end
                    if (r_g == c_glast) begin
                        r_state <= S_DONE;
                    end else begin
                        r_g <= w_gnext;
                        r_k <= '0;
                        for (int l = 0; l < LANES; l++) begin
                            r_acc[l] <= w_bias[l];
                        end
                        r_state <= S_MAC;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    y       <= r_buf;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
